id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register with load-use hazard detection. Captures decoded operands,
//  source/dest register IDs and control from decode, presents them to execute and to the
//  forwarding unit (exOp1/exOp2 feed its op1/op2). Inserts a bubble and stalls IF/ID when a
//  load in EX writes a register the ID instruction reads. Counts inserted load-use bubbles.
// PARAMETERS
//  DATA_W   16  operand/immediate width
//  REG_W    4   register-ID width (register 0 is hardwired zero, never a hazard)
//  ALUOP_W  4   ALU opcode width
//  CNT_W    16  bubble counter width (saturating)
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous reset, active-high
//  idValid      in   1        decode slot holds a real instruction
//  idOp1        in   REG_W    source reg 1 ID
//  idOp2        in   REG_W    source reg 2 ID
//  idRd         in   REG_W    destination reg ID
//  idRegWrite   in   1        instruction writes idRd
//  idMemRead    in   1        instruction is a load
//  idData1      in   DATA_W   register-file read value 1
//  idData2      in   DATA_W   register-file read value 2
//  idImm        in   DATA_W   sign-extended immediate
//  idAluOp      in   ALUOP_W  ALU opcode
//  flush        in   1        branch-taken squash of ID/EX contents
//  extHold      in   1        downstream not ready: freeze EX register
//  exValid      out  1        EX slot valid
//  exOp1/exOp2  out  REG_W    registered source IDs (to forwarding unit)
//  exRd         out  REG_W    registered dest ID
//  exRegWrite   out  1        registered, forced 0 in a bubble
//  exMemRead    out  1        registered, forced 0 in a bubble
//  exData1/exData2/exImm out DATA_W  registered operands
//  exAluOp      out  ALUOP_W  registered opcode
//  stall        out  1        combinational: IF/ID and PC must hold this cycle
//  bubbleCount  out  CNT_W    load-use bubbles inserted since reset
// BEHAVIOUR
//  - Reset (async, any time incl. mid-stall): every registered output and bubbleCount -> 0;
//    stall then evaluates to extHold only (loadUse needs exValid=1).
//  - loadUse = idValid & exValid & exMemRead & (exRd!=0) & (exRd==idOp1 | exRd==idOp2).
//  - stall = extHold | (loadUse & ~flush). Purely combinational, same cycle.
//  - Per rising edge, priority flush > extHold > loadUse > load:
//    flush:   bubble (exValid, exRegWrite, exMemRead, exRd, exOp1, exOp2 -> 0; data don't-care
//             but driven 0).
//    extHold: all EX outputs keep value; bubbleCount unchanged.
//    loadUse: bubble as above; bubbleCount += 1, saturating at 2^CNT_W-1.
//    else:    capture all id* fields; exValid<=idValid; if idValid=0 control bits forced 0.
//  - Latency: 1 cycle ID->EX. A load-use pair costs exactly one bubble; on the next cycle the
//    load is in MEM, loadUse deasserts, and forwarding covers the value.
//  - idOp==0 never triggers loadUse even if exRd matches (exRd=0 excluded).
//  - flush with loadUse same cycle: bubble inserted, counter NOT incremented, stall=extHold.
//  - extHold with loadUse same cycle: hold wins, no count; re-evaluated when hold drops.
//  - Counter saturates, never wraps.
// TESTING
//  1 rst=1 mid-run with exValid=1,bubbleCount=5 -> all ex* and bubbleCount read 0 before next edge.
//  2 EX: load exRd=3; ID: idOp2=3 idValid=1 -> stall=1, next edge exValid=0 exRegWrite=0,
//    bubbleCount=1; following cycle stall=0 and ID instr captured.
//  3 EX: load exRd=0; ID: idOp1=0 -> stall=0, no bubble, bubbleCount unchanged.
//  4 loadUse + flush same cycle -> stall=0, EX bubble, bubbleCount unchanged.
//  5 extHold=1 for 3 cycles with new ID data -> ex* unchanged, stall=1; release -> capture.
//  6 CNT_W=2, 5 consecutive load-use events -> bubbleCount stops at 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with load-use hazard detection and a
//   saturating count of the load-use bubbles it inserts.
// Latency: 1 cycle from decode fields to ex* outputs; stall is combinational.
// Backpressure: extHold freezes the EX register; stall asks IF/ID and PC to hold.
//
// Ports:
//   clk, rst                     rising-edge clock, asynchronous active-high reset
//   idValid                      decode slot holds a real instruction
//   idOp1, idOp2, idRd           source / destination register IDs from decode
//   idRegWrite, idMemRead        decode control (writes idRd / is a load)
//   idData1, idData2, idImm      register-file read values and sign-extended immediate
//   idAluOp                      ALU opcode
//   flush                        branch-taken squash of the ID/EX contents
//   extHold                      downstream not ready: freeze the EX register
//   exValid ... exAluOp          registered copies of the decode fields for execute
//                                and the forwarding unit (exOp1/exOp2 feed its op1/op2)
//   stall                        combinational: IF/ID and PC must hold this cycle
//   bubbleCount                  load-use bubbles inserted since reset (saturating)
module id_ex_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               idValid,
  input  logic [REG_W-1:0]   idOp1,
  input  logic [REG_W-1:0]   idOp2,
  input  logic [REG_W-1:0]   idRd,
  input  logic               idRegWrite,
  input  logic               idMemRead,
  input  logic [DATA_W-1:0]  idData1,
  input  logic [DATA_W-1:0]  idData2,
  input  logic [DATA_W-1:0]  idImm,
  input  logic [ALUOP_W-1:0] idAluOp,
  input  logic               flush,
  input  logic               extHold,
  output logic               exValid,
  output logic [REG_W-1:0]   exOp1,
  output logic [REG_W-1:0]   exOp2,
  output logic [REG_W-1:0]   exRd,
  output logic               exRegWrite,
  output logic               exMemRead,
  output logic [DATA_W-1:0]  exData1,
  output logic [DATA_W-1:0]  exData2,
  output logic [DATA_W-1:0]  exImm,
  output logic [ALUOP_W-1:0] exAluOp,
  output logic               stall,
  output logic [CNT_W-1:0]   bubbleCount
);

  logic src_match;
  logic load_use;
  logic insert_bubble;
  logic count_bubble;
  logic count_full;

  // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
  assign src_match = (exRd == idOp1) || (exRd == idOp2);
  assign load_use  = idValid && exValid && exMemRead && (exRd != '0) && src_match;

  // A flush squashes the dependent instruction anyway, so it must not stall IF/ID.
  assign stall = extHold || (load_use && !flush);

  // Priority flush > extHold > load-use > capture. A flush bubbles even while held;
  // a load-use bubble only goes in once the hold has dropped.
  assign insert_bubble = flush || (!extHold && load_use);
  // Only genuine load-use bubbles are counted, never flush bubbles.
  assign count_bubble  = !flush && !extHold && load_use;
  assign count_full    = (bubbleCount == {CNT_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exValid    <= 1'b0;
      exOp1      <= '0;
      exOp2      <= '0;
      exRd       <= '0;
      exRegWrite <= 1'b0;
      exMemRead  <= 1'b0;
      exData1    <= '0;
      exData2    <= '0;
      exImm      <= '0;
      exAluOp    <= '0;
    end else if (insert_bubble) begin
      // Bubble: control and register IDs cleared so neither the hazard check nor
      // forwarding can match it; data is don't-care but driven to zero.
      exValid    <= 1'b0;
      exOp1      <= '0;
      exOp2      <= '0;
      exRd       <= '0;
      exRegWrite <= 1'b0;
      exMemRead  <= 1'b0;
      exData1    <= '0;
      exData2    <= '0;
      exImm      <= '0;
      exAluOp    <= '0;
    end else if (!extHold) begin
      exValid    <= idValid;
      exOp1      <= idOp1;
      exOp2      <= idOp2;
      exRd       <= idRd;
      // An empty decode slot must not write back or look like a load.
      exRegWrite <= idValid && idRegWrite;
      exMemRead  <= idValid && idMemRead;
      exData1    <= idData1;
      exData2    <= idData2;
      exImm      <= idImm;
      exAluOp    <= idAluOp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubbleCount <= '0;
    end else if (count_bubble && !count_full) begin
      bubbleCount <= bubbleCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. Each step drives one cycle of decode inputs
// #1 after the rising edge and queues the expected stall (for those inputs) and
// EX state (from the previous edge); a monitor pops and compares on the falling edge.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [3:0]  rd;
    logic        rw;
    logic        mr;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] imm;
    logic [3:0]  alu;
  } st_t;

  typedef struct packed {
    logic rst;
    logic fl;
    logic hold;
    st_t  f;
  } in_t;

  typedef struct packed {
    logic        stall;
    st_t         s;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        idValid, idRegWrite, idMemRead, flush, extHold;
  logic [3:0]  idOp1, idOp2, idRd, idAluOp;
  logic [15:0] idData1, idData2, idImm;

  logic        exValid, exRegWrite, exMemRead, stall;
  logic [3:0]  exOp1, exOp2, exRd, exAluOp;
  logic [15:0] exData1, exData2, exImm, bubbleCount;

  logic        s_exValid, s_exRegWrite, s_exMemRead, s_stall;
  logic [3:0]  s_exOp1, s_exOp2, s_exRd, s_exAluOp;
  logic [15:0] s_exData1, s_exData2, s_exImm;
  logic [1:0]  s_bubbleCount;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .idValid(idValid), .idOp1(idOp1), .idOp2(idOp2), .idRd(idRd),
    .idRegWrite(idRegWrite), .idMemRead(idMemRead), .idData1(idData1), .idData2(idData2),
    .idImm(idImm), .idAluOp(idAluOp), .flush(flush), .extHold(extHold),
    .exValid(exValid), .exOp1(exOp1), .exOp2(exOp2), .exRd(exRd),
    .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exData1(exData1),
    .exData2(exData2), .exImm(exImm), .exAluOp(exAluOp), .stall(stall),
    .bubbleCount(bubbleCount)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .idValid(idValid), .idOp1(idOp1), .idOp2(idOp2), .idRd(idRd),
    .idRegWrite(idRegWrite), .idMemRead(idMemRead), .idData1(idData1), .idData2(idData2),
    .idImm(idImm), .idAluOp(idAluOp), .flush(flush), .extHold(extHold),
    .exValid(s_exValid), .exOp1(s_exOp1), .exOp2(s_exOp2), .exRd(s_exRd),
    .exRegWrite(s_exRegWrite), .exMemRead(s_exMemRead), .exData1(s_exData1),
    .exData2(s_exData2), .exImm(s_exImm), .exAluOp(s_exAluOp), .stall(s_stall),
    .bubbleCount(s_bubbleCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    total  = 0;
  int    passed = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  task automatic chk(input string t, input string f, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s.%s: got %0h, expected %0h", t, f, act, req);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each falling edge.
  exp_t  me;
  string mt;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      mt = tag_q.pop_front();
      chk(mt, "stall", {63'd0, stall}, {63'd0, me.stall});
      chk(mt, "exValid", {63'd0, exValid}, {63'd0, me.s.v});
      chk(mt, "ctrl", {50'd0, exOp1, exOp2, exRd, exRegWrite, exMemRead},
          {50'd0, me.s.op1, me.s.op2, me.s.rd, me.s.rw, me.s.mr});
      chk(mt, "data", {12'd0, exData1, exData2, exImm, exAluOp},
          {12'd0, me.s.d1, me.s.d2, me.s.imm, me.s.alu});
      chk(mt, "bubbleCount", {48'd0, bubbleCount}, {48'd0, me.cnt});
      chk(mt, "satCount", {62'd0, s_bubbleCount}, {62'd0, me.cnt2});
    end
  end

  function automatic st_t mk(input logic v, input logic [3:0] o1, input logic [3:0] o2,
                             input logic [3:0] rd, input logic rw, input logic mr,
                             input logic [15:0] d1, input logic [15:0] d2,
                             input logic [15:0] imm, input logic [3:0] alu);
    st_t s;
    s.v = v; s.op1 = o1; s.op2 = o2; s.rd = rd; s.rw = rw; s.mr = mr;
    s.d1 = d1; s.d2 = d2; s.imm = imm; s.alu = alu;
    return s;
  endfunction

  function automatic in_t mod(input st_t f, input logic fl, input logic hold, input logic r);
    in_t i;
    i.rst = r; i.fl = fl; i.hold = hold; i.f = f;
    return i;
  endfunction

  function automatic in_t pl(input st_t f);
    return mod(f, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic step(input string t, input in_t i, input logic st, input st_t s,
                      input int c, input int c2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = i.rst; flush = i.fl; extHold = i.hold;
    idValid = i.f.v; idOp1 = i.f.op1; idOp2 = i.f.op2; idRd = i.f.rd;
    idRegWrite = i.f.rw; idMemRead = i.f.mr; idData1 = i.f.d1; idData2 = i.f.d2;
    idImm = i.f.imm; idAluOp = i.f.alu;
    e.stall = st; e.s = s; e.cnt = 16'(c); e.cnt2 = 2'(c2);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  st_t I_LD, I_USE, I_IDLE, I_LD0, I_USE0, I_A, I_B, I_C, I_D;
  st_t S_ZERO, S_IDLE;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; extHold = 1'b0;
    idValid = 1'b0; idOp1 = '0; idOp2 = '0; idRd = '0; idRegWrite = 1'b0;
    idMemRead = 1'b0; idData1 = '0; idData2 = '0; idImm = '0; idAluOp = '0;

    I_LD   = mk(1, 4'd1, 4'd2, 4'd3, 1, 1, 16'h1111, 16'h2222, 16'h0004, 4'd0);
    I_USE  = mk(1, 4'd5, 4'd3, 4'd6, 1, 0, 16'hAAAA, 16'hBBBB, 16'h0010, 4'd2);
    I_IDLE = mk(0, 4'd0, 4'd0, 4'd7, 1, 1, 16'h0000, 16'h0000, 16'h0000, 4'd0);
    I_LD0  = mk(1, 4'd4, 4'd0, 4'd0, 0, 1, 16'h0101, 16'h0202, 16'h0303, 4'd1);
    I_USE0 = mk(1, 4'd0, 4'd9, 4'd8, 1, 0, 16'h0C0C, 16'h0D0D, 16'h0E0E, 4'd3);
    I_A    = mk(1, 4'd1, 4'd2, 4'd4, 1, 0, 16'h1234, 16'h5678, 16'h9ABC, 4'd5);
    I_B    = mk(1, 4'd3, 4'd4, 4'd5, 1, 1, 16'h1000, 16'h2000, 16'h3000, 4'd6);
    I_C    = mk(1, 4'd6, 4'd7, 4'd8, 0, 0, 16'h4000, 16'h5000, 16'h6000, 4'd7);
    I_D    = mk(1, 4'd9, 4'd10, 4'd11, 1, 0, 16'h7000, 16'h8000, 16'h9000, 4'd8);
    S_ZERO = mk(0, 4'd0, 4'd0, 4'd0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0);
    // Invalid slot captured: fields pass through, control bits forced low.
    S_IDLE = mk(0, 4'd0, 4'd0, 4'd7, 0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0);

    //   tag              inputs                        stall state   cnt sat
    step("reset",         mod(I_IDLE, 0, 0, 1),         0, S_ZERO, 0, 0);
    step("load_in",       pl(I_LD),                     0, S_ZERO, 0, 0);
    step("lu_detect",     pl(I_USE),                    1, I_LD,   0, 0);
    step("lu_bubble",     pl(I_USE),                    0, S_ZERO, 1, 1);
    step("lu_capture",    pl(I_IDLE),                   0, I_USE,  1, 1);
    step("idle_forced",   pl(I_LD0),                    0, S_IDLE, 1, 1);
    step("rd0_no_stall",  pl(I_USE0),                   0, I_LD0,  1, 1);
    step("rd0_captured",  pl(I_IDLE),                   0, I_USE0, 1, 1);
    step("fl_load",       pl(I_LD),                     0, S_IDLE, 1, 1);
    step("flush_lu",      mod(I_USE, 1, 0, 0),          0, I_LD,   1, 1);
    step("flush_bubble",  pl(I_A),                      0, S_ZERO, 1, 1);
    step("hold1",         mod(I_B, 0, 1, 0),            1, I_A,    1, 1);
    step("hold2",         mod(I_C, 0, 1, 0),            1, I_A,    1, 1);
    step("hold3",         mod(I_D, 0, 1, 0),            1, I_A,    1, 1);
    step("hold_release",  pl(I_D),                      0, I_A,    1, 1);
    step("rel_capture",   pl(I_IDLE),                   0, I_D,    1, 1);
    step("hl_load",       pl(I_LD),                     0, S_IDLE, 1, 1);
    step("hold_lu",       mod(I_USE, 0, 1, 0),          1, I_LD,   1, 1);
    step("lu_after_hold", pl(I_USE),                    1, I_LD,   1, 1);
    step("hl_bubble",     pl(I_USE),                    0, S_ZERO, 2, 2);
    step("hl_capture",    pl(I_IDLE),                   0, I_USE,  2, 2);

    for (int k = 0; k < 3; k++) begin
      step("sat_load",    pl(I_LD),                     0, S_IDLE, 2 + k, (2 + k > 3) ? 3 : 2 + k);
      step("sat_detect",  pl(I_USE),                    1, I_LD,   2 + k, (2 + k > 3) ? 3 : 2 + k);
      step("sat_bubble",  pl(I_USE),                    0, S_ZERO, 3 + k, 3);
      step("sat_capture", pl(I_IDLE),                   0, I_USE,  3 + k, 3);
    end

    step("pre_reset",     pl(I_LD),                     0, S_IDLE, 5, 3);
    step("reset_mid",     mod(I_USE, 0, 1, 1),          1, S_ZERO, 0, 0);
    step("reset_hold0",   mod(I_USE, 0, 0, 1),          0, S_ZERO, 0, 0);
    step("post_rst_ld",   pl(I_LD),                     0, S_ZERO, 0, 0);
    step("post_rst_cap",  pl(I_IDLE),                   0, I_LD,   0, 0);

    @(negedge clk);
    #1;
    chk("drain", "queue", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
